store_monitor: RTL and testbench
================================

Name: store_monitor

Overview:
- Synthesizable self-check stage directly downstream of the processor `top`; it observes the data-memory write port.
- Classifies every store as ignored, pass or fail.
- Raises sticky done/pass/fail status and keeps cycle and store statistics.
- Allows the same program-level check to run on FPGA (LEDs) and in simulation without a behavioural bench.

Parameters:
- PASS_ADR, 32'd100, store address that ends the test.
- PASS_DATA, 32'd7, data required at PASS_ADR for a pass.
- IGNORE_ADR, 32'd96, store address that is legal scratch and does not end the test.
- TIMEOUT_CYCLES, 32'd1000, RUN cycles before a timeout failure; 0 disables the timeout.
- CNT_W, 16, width of store_count.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; same reset that drives `top`.
- MemWrite  input  1  store strobe from `top`.
- DataAdr  input  32  store address from `top`.
- WriteData  input  32  store data from `top`.
- done  output  1  sticky; test has ended.
- pass  output  1  sticky; ended by a PASS_ADR/PASS_DATA store.
- fail  output  1  sticky; ended by a bad store or a timeout.
- timeout  output  1  sticky; fail was caused by the timeout.
- state  output  2  00 RUN, 01 PASS, 10 FAIL, 11 reserved (never driven).
- store_count  output  CNT_W  accepted stores; saturates at all-ones.
- cycle_count  output  32  RUN cycles since reset deassertion.
- last_adr  output  32  DataAdr of the most recent accepted store.
- last_data  output  32  WriteData of the most recent accepted store.

Behaviour:
- Single clock; reset is synchronous, active-high (clk/reset as in `top`).
- While reset=1 at a rising edge, everything clears:
  - state=RUN; done, pass, fail and timeout = 0.
  - store_count=0, cycle_count=0, last_adr=0, last_data=0.
- All outputs are registered. An event sampled at edge N is visible after edge N.
- The first sampled cycle is the first edge with reset=0. Stores seen during reset are discarded.
- RUN, each edge with reset=0:
  - cycle_count increments by 1 (wraps at 2^32, with no other effect).
  - If MemWrite=1:
    - The store is accepted: last_adr/last_data load the bus values; store_count increments (saturating).
    - DataAdr==PASS_ADR and WriteData==PASS_DATA -> PASS; done=1, pass=1.
    - DataAdr==PASS_ADR and wrong data -> FAIL; done=1, fail=1.
    - DataAdr==IGNORE_ADR -> stay in RUN.
    - Any other address -> FAIL; done=1, fail=1.
  - Else if TIMEOUT_CYCLES!=0 and the post-increment cycle_count==TIMEOUT_CYCLES -> FAIL; done=1, fail=1, timeout=1.
  - Simultaneous store and timeout: the store classification wins and timeout stays 0.
- PASS/FAIL are terminal:
  - Counters, last_* and flags freeze.
  - Further stores are not accepted.
  - Only reset exits.
- Reset asserted mid-run or after a terminal state returns to the reset values on the next edge. This takes priority over any concurrent store.
- X/Z on the inputs is not handled. Inputs are assumed valid whenever MemWrite=1.
- pass and fail are never both 1. done == pass|fail. state matches the flags.
- Comparisons are full 32-bit equality. There is no byte-enable handling.

Test Plan:
- Reset held 22 ns (10 ns clock), then store (96,5), then (100,7) -> after the first store: state RUN, store_count=1. After the second: pass=1, done=1, store_count=2, last_adr=100, last_data=7.
- Store (100,8) -> fail=1, timeout=0, last_data=8. A following store (100,7) is ignored: store_count stays 1 and pass stays 0.
- Store (104,7) -> fail=1 on the next edge. PASS_ADR is not required.
- No stores with TIMEOUT_CYCLES=20 -> fail=1, timeout=1, cycle_count=20 after the 20th post-reset edge. Counters then frozen for 10 more cycles.
- Store (100,7) on the same edge the timeout expires -> pass=1, timeout=0.
- Reset pulsed for 1 cycle after PASS, then store (96,1) -> all flags 0, cycle_count restarts from 0, store_count=1, state RUN.

Source files
------------

// File: rtl/store_monitor.sv
// store_monitor: self-check stage that watches the data-memory write port of
// the processor and reports a sticky pass/fail verdict along with run statistics.
//
// Ports:
//   clk          system clock; all logic on the rising edge
//   reset        synchronous, active-high; shared with the processor
//   MemWrite     store strobe
//   DataAdr      store address
//   WriteData    store data
//   done         sticky; the test has ended
//   pass         sticky; ended by a PASS_ADR/PASS_DATA store
//   fail         sticky; ended by a bad store or a timeout
//   timeout      sticky; the fail was caused by the timeout
//   state        00 RUN, 01 PASS, 10 FAIL (11 never driven)
//   store_count  accepted stores, saturating at all-ones
//   cycle_count  RUN cycles since reset deassertion
//   last_adr     address of the most recent accepted store
//   last_data    data of the most recent accepted store
module store_monitor #(
  parameter logic [31:0] PASS_ADR       = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] IGNORE_ADR     = 32'd96,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] store_count,
  output logic [31:0]      cycle_count,
  output logic [31:0]      last_adr,
  output logic [31:0]      last_data
);

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StPass = 2'b01,
    StFail = 2'b10
  } state_e;

  state_e             r_state, w_state_d;
  logic               r_done, w_done_d;
  logic               r_pass, w_pass_d;
  logic               r_fail, w_fail_d;
  logic               r_timeout, w_timeout_d;
  logic [CNT_W-1:0]   r_store_cnt, w_store_cnt_d;
  logic [31:0]        r_cycle_cnt, w_cycle_cnt_d;
  logic [31:0]        r_last_adr, w_last_adr_d;
  logic [31:0]        r_last_data, w_last_data_d;

  always_comb begin
    w_state_d     = r_state;
    w_timeout_d   = r_timeout;
    w_store_cnt_d = r_store_cnt;
    w_cycle_cnt_d = r_cycle_cnt;
    w_last_adr_d  = r_last_adr;
    w_last_data_d = r_last_data;

    // Terminal states hold everything; only RUN advances.
    if (r_state == StRun) begin
      w_cycle_cnt_d = r_cycle_cnt + 32'd1;
      if (MemWrite) begin
        w_last_adr_d  = DataAdr;
        w_last_data_d = WriteData;
        if (r_store_cnt != {CNT_W{1'b1}}) begin
          w_store_cnt_d = r_store_cnt + 1'b1;
        end
        if (DataAdr == PASS_ADR) begin
          w_state_d = (WriteData == PASS_DATA) ? StPass : StFail;
        end else if (DataAdr != IGNORE_ADR) begin
          w_state_d = StFail;
        end
      end else if ((TIMEOUT_CYCLES != 32'd0) && (w_cycle_cnt_d == TIMEOUT_CYCLES)) begin
        // A store on the same edge takes the branch above, so timeout stays 0 then.
        w_state_d   = StFail;
        w_timeout_d = 1'b1;
      end
    end

    w_done_d = (w_state_d != StRun);
    w_pass_d = (w_state_d == StPass);
    w_fail_d = (w_state_d == StFail);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_store_cnt <= '0;
      r_cycle_cnt <= '0;
      r_last_adr  <= '0;
      r_last_data <= '0;
    end else begin
      r_state     <= w_state_d;
      r_done      <= w_done_d;
      r_pass      <= w_pass_d;
      r_fail      <= w_fail_d;
      r_timeout   <= w_timeout_d;
      r_store_cnt <= w_store_cnt_d;
      r_cycle_cnt <= w_cycle_cnt_d;
      r_last_adr  <= w_last_adr_d;
      r_last_data <= w_last_data_d;
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign state       = r_state;
  assign store_count = r_store_cnt;
  assign cycle_count = r_cycle_cnt;
  assign last_adr    = r_last_adr;
  assign last_data   = r_last_data;

endmodule

// File: tb/tb_store_monitor.sv
// Testbench for store_monitor: a behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized stores and resets.
module tb_store_monitor;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        done, pass, fail, timeout;
  logic [1:0]  state;
  logic [15:0] store_count;
  logic [31:0] cycle_count, last_adr, last_data;

  int checks = 0;
  int failures = 0;

  // Behavioural model: verdict 0 running, 1 passed, 2 failed.
  int          m_verdict = 0;
  bit          m_to = 0;
  int unsigned m_stores = 0;
  int unsigned m_cycles = 0;
  logic [31:0] m_adr = 0;
  logic [31:0] m_data = 0;

  store_monitor #(
    .PASS_ADR       (32'd100),
    .PASS_DATA      (32'd7),
    .IGNORE_ADR     (32'd96),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .state       (state),
    .store_count (store_count),
    .cycle_count (cycle_count),
    .last_adr    (last_adr),
    .last_data   (last_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_verdict = 0; m_to = 0; m_stores = 0; m_cycles = 0; m_adr = 0; m_data = 0;
    end else if (m_verdict == 0) begin
      m_cycles = m_cycles + 1;
      if (MemWrite) begin
        if (m_stores < 65535) m_stores = m_stores + 1;
        m_adr  = DataAdr;
        m_data = WriteData;
        if (DataAdr == 100) m_verdict = (WriteData == 7) ? 1 : 2;
        else if (DataAdr != 96) m_verdict = 2;
      end else if (m_cycles == TO) begin
        m_verdict = 2;
        m_to = 1;
      end
    end
  endtask

  // Model advances on each rising edge; outputs compared shortly afterwards.
  always begin
    @(posedge clk);
    model_edge();
    #1;
    check("state", state, m_verdict);
    check("done", done, m_verdict != 0);
    check("pass", pass, m_verdict == 1);
    check("fail", fail, m_verdict == 2);
    check("timeout", timeout, m_to);
    check("store_count", store_count, m_stores);
    check("cycle_count", cycle_count, m_cycles);
    check("last_adr", last_adr, m_adr);
    check("last_data", last_data, m_data);
  end

  task automatic drive_now(input logic w, input logic [31:0] a, input logic [31:0] d);
    MemWrite = w; DataAdr = a; WriteData = d;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_now(w, a, d);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // One reset edge; returns at the following falling edge with reset low.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_now(1'b1, 32'd100, 32'd7);  // store under reset must be discarded
    @(negedge clk);
    reset = 1'b0;
    drive_now(1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive_now(1'b1, 32'd104, 32'd3);
    #22;
    reset = 1'b0;

    // Ignore store then passing store.
    drive_now(1'b1, 32'd96, 32'd5);
    settle();
    check("t1_state_run", state, 2'b00);
    check("t1_cnt", store_count, 1);
    drive(1'b1, 32'd100, 32'd7);
    settle();
    check("t1_pass", pass, 1);
    check("t1_done", done, 1);
    check("t1_cnt2", store_count, 2);
    check("t1_adr", last_adr, 100);
    check("t1_data", last_data, 7);
    drive(1'b0, 32'd0, 32'd0);

    // Wrong data at PASS_ADR; later store not accepted.
    do_reset();
    drive_now(1'b1, 32'd100, 32'd8);
    settle();
    check("t2_fail", fail, 1);
    check("t2_timeout", timeout, 0);
    check("t2_data", last_data, 8);
    drive(1'b1, 32'd100, 32'd7);
    settle();
    check("t2_cnt_frozen", store_count, 1);
    check("t2_no_pass", pass, 0);
    drive(1'b0, 32'd0, 32'd0);

    // Bad address.
    do_reset();
    drive_now(1'b1, 32'd104, 32'd7);
    settle();
    check("t3_fail", fail, 1);
    check("t3_state", state, 2'b10);
    drive(1'b0, 32'd0, 32'd0);

    // Timeout with no stores, then frozen.
    do_reset();
    repeat (19) settle();
    check("t4_not_yet", fail, 0);
    settle();
    check("t4_fail", fail, 1);
    check("t4_timeout", timeout, 1);
    check("t4_cycles", cycle_count, 20);
    repeat (10) settle();
    check("t4_frozen", cycle_count, 20);

    // Pass store on the timeout edge wins.
    do_reset();
    repeat (19) settle();
    drive(1'b1, 32'd100, 32'd7);
    settle();
    check("t5_pass", pass, 1);
    check("t5_timeout", timeout, 0);
    check("t5_cycles", cycle_count, 20);
    drive(1'b0, 32'd0, 32'd0);

    // Reset after PASS, then ignore store.
    do_reset();
    check("t6_cyc0", cycle_count, 0);
    check("t6_done0", done, 0);
    drive_now(1'b1, 32'd96, 32'd1);
    settle();
    check("t6_flags", {done, pass, fail, timeout}, 4'b0000);
    check("t6_cycles", cycle_count, 1);
    check("t6_cnt", store_count, 1);
    check("t6_state", state, 2'b00);

    // Random stores and resets.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [31:0] a;
      logic [31:0] d;
      @(negedge clk);
      reset = ($urandom_range(0, (m_verdict != 0) ? 5 : 80) == 0);
      r = $urandom_range(0, 9);
      a = (r < 5) ? 32'd96 : (r < 7) ? 32'd100 : (r < 8) ? 32'd104 : $urandom;
      d = ($urandom_range(0, 9) < 7) ? 32'd7 : $urandom;
      drive_now($urandom_range(0, 11) == 0, a, d);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_now(1'b0, 32'd0, 32'd0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
